// File: rtl/frm_timing_mon_if.sv
`default_nettype none
// ============================================================================
// frm_timing_mon_if : vsync/clear inputs and frame status outputs of the monitor
// Rev 1.0
// ============================================================================
interface frm_timing_mon_if #(
   parameter int CNT_W = 9,
   parameter int PER_W = 24
);
   logic             vsync;
   logic             cnt_clr;
   logic             frm_tick;
   logic [CNT_W-1:0] frm_cnt;
   logic [PER_W-1:0] frm_period;
   logic             frm_period_vld;
   logic             per_sat;
   logic             vs_lost;

   // Timing source / status consumer side
   modport master (
      output vsync,
      output cnt_clr,
      input  frm_tick,
      input  frm_cnt,
      input  frm_period,
      input  frm_period_vld,
      input  per_sat,
      input  vs_lost
   );

   // Monitor side
   modport slave (
      input  vsync,
      input  cnt_clr,
      output frm_tick,
      output frm_cnt,
      output frm_period,
      output frm_period_vld,
      output per_sat,
      output vs_lost
   );
endinterface
`default_nettype wire

// File: rtl/frm_timing_mon.sv
`default_nettype none
// ============================================================================
// frm_timing_mon : vsync resynchroniser, frame counter, period and loss monitor
// Rev 1.0
// ============================================================================
module frm_timing_mon #(
   parameter int CNT_W       = 9,
   parameter int CNT_MAX     = 511,
   parameter int VS_POL      = 1,
   parameter int SYNC_STAGES = 2,
   parameter int PER_W       = 24,
   parameter int TIMEOUT     = 2000000
) (
   input wire              disp_clk,
   input wire              disp_rst_n,
   frm_timing_mon_if.slave mon
);

   localparam logic             c_IDLE_LVL = (VS_POL == 0);
   localparam logic [CNT_W-1:0] c_CNT_MAX  = CNT_W'(CNT_MAX);
   localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [PER_W-1:0] c_PER_MAX  = {PER_W{1'b1}};
   localparam logic [PER_W:0]   c_PER_ONE  = {{PER_W{1'b0}}, 1'b1};
   localparam logic [PER_W:0]   c_TIMEOUT  = (PER_W+1)'(TIMEOUT);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_prev_q;
   logic                   s_last;
   logic                   vs_edge;

   logic                   frm_tick_q,       frm_tick_d;
   logic [CNT_W-1:0]       frm_cnt_q,        frm_cnt_d;
   logic [PER_W-1:0]       frm_period_q,     frm_period_d;
   logic                   frm_period_vld_q, frm_period_vld_d;
   logic                   per_sat_q,        per_sat_d;
   logic                   vs_lost_q,        vs_lost_d;
   logic [PER_W-1:0]       per_cnt_q,        per_cnt_d;
   logic                   ref_ok_q,         ref_ok_d;

   logic [PER_W:0]         per_inc;
   logic                   per_full;

   // Synchroniser chain plus history flop; reset parks them at the idle level
   // so a released reset never fakes an edge unless vsync is already active.
   always_ff @(posedge disp_clk) begin
      if (!disp_rst_n) begin
         sync_q   <= {SYNC_STAGES{c_IDLE_LVL}};
         s_prev_q <= c_IDLE_LVL;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], mon.vsync};
         s_prev_q <= s_last;
      end
   end

   assign s_last  = sync_q[SYNC_STAGES-1];
   assign vs_edge = (VS_POL != 0) ? (s_last & ~s_prev_q) : (~s_last & s_prev_q);

   assign per_inc  = {1'b0, per_cnt_q} + c_PER_ONE;
   assign per_full = &per_cnt_q;

   always_comb begin
      frm_tick_d       = 1'b0;
      frm_period_vld_d = 1'b0;
      frm_cnt_d        = frm_cnt_q;
      frm_period_d     = frm_period_q;
      per_sat_d        = per_sat_q;
      vs_lost_d        = vs_lost_q;
      per_cnt_d        = per_cnt_q;
      ref_ok_d         = ref_ok_q;

      if (mon.cnt_clr) begin
         frm_cnt_d = '0;
         per_cnt_d = '0;
         ref_ok_d  = 1'b0;
         vs_lost_d = 1'b0;
         per_sat_d = 1'b0;
      end else if (vs_edge) begin
         frm_tick_d = 1'b1;
         frm_cnt_d  = (frm_cnt_q == c_CNT_MAX) ? '0 : frm_cnt_q + c_CNT_ONE;
         // The edge closes the current gap, which is per_cnt idle cycles plus this one.
         if (ref_ok_q) begin
            frm_period_d     = per_full ? c_PER_MAX : per_inc[PER_W-1:0];
            frm_period_vld_d = 1'b1;
            per_sat_d        = per_sat_q | per_full;
         end
         ref_ok_d  = 1'b1;
         per_cnt_d = '0;
         vs_lost_d = 1'b0;
      end else begin
         per_cnt_d = per_full ? per_cnt_q : per_inc[PER_W-1:0];
         if (per_inc == c_TIMEOUT) begin
            vs_lost_d = 1'b1;
         end
      end
   end

   always_ff @(posedge disp_clk) begin
      if (!disp_rst_n) begin
         frm_tick_q       <= 1'b0;
         frm_cnt_q        <= '0;
         frm_period_q     <= '0;
         frm_period_vld_q <= 1'b0;
         per_sat_q        <= 1'b0;
         vs_lost_q        <= 1'b0;
         per_cnt_q        <= '0;
         ref_ok_q         <= 1'b0;
      end else begin
         frm_tick_q       <= frm_tick_d;
         frm_cnt_q        <= frm_cnt_d;
         frm_period_q     <= frm_period_d;
         frm_period_vld_q <= frm_period_vld_d;
         per_sat_q        <= per_sat_d;
         vs_lost_q        <= vs_lost_d;
         per_cnt_q        <= per_cnt_d;
         ref_ok_q         <= ref_ok_d;
      end
   end

   assign mon.frm_tick       = frm_tick_q;
   assign mon.frm_cnt        = frm_cnt_q;
   assign mon.frm_period     = frm_period_q;
   assign mon.frm_period_vld = frm_period_vld_q;
   assign mon.per_sat        = per_sat_q;
   assign mon.vs_lost        = vs_lost_q;

endmodule
`default_nettype wire

// File: tb/tb_frm_timing_mon.sv
`default_nettype none
// ============================================================================
// tb_frm_timing_mon : two monitor instances (rising/falling vsync) checked
// against a scoreboard of expected frame ticks. Rev 1.0
// ============================================================================
module tb_frm_timing_mon;

   localparam int A_CMAX = 4;
   localparam int B_CMAX = 511;
   localparam int A_PMAX = (1 << 24) - 1;
   localparam int B_PMAX = 255;

   typedef struct {
      int cnt;
      int vld;
      int per;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   exp_t q_a[$];
   exp_t q_b[$];
   int   m_cnt[2];
   int   m_ref[2];
   int   m_last[2];
   int   m_per[2];
   logic prev_tick_a = 1'b0;
   logic prev_tick_b = 1'b0;

   frm_timing_mon_if #(.CNT_W(9), .PER_W(24)) if_a ();
   frm_timing_mon_if #(.CNT_W(9), .PER_W(8))  if_b ();

   frm_timing_mon #(
      .CNT_W(9), .CNT_MAX(A_CMAX), .VS_POL(1), .SYNC_STAGES(2), .PER_W(24), .TIMEOUT(300)
   ) u_a (
      .disp_clk  (clk),
      .disp_rst_n(rst_n),
      .mon       (if_a)
   );

   frm_timing_mon #(
      .CNT_W(9), .CNT_MAX(B_CMAX), .VS_POL(0), .SYNC_STAGES(2), .PER_W(8), .TIMEOUT(200)
   ) u_b (
      .disp_clk  (clk),
      .disp_rst_n(rst_n),
      .mon       (if_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sb_pop(input int d, input logic [31:0] cnt, input logic [31:0] vld,
                         input logic [31:0] per);
      exp_t e;
      int   sz;
      sz = (d == 0) ? q_a.size() : q_b.size();
      check((d == 0) ? "a_tick_expected" : "b_tick_expected", 32'(sz != 0), 1);
      if (sz == 0) return;
      e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
      check((d == 0) ? "a_frm_cnt" : "b_frm_cnt", cnt, e.cnt);
      check((d == 0) ? "a_period_vld" : "b_period_vld", vld, e.vld);
      check((d == 0) ? "a_frm_period" : "b_frm_period", per, e.per);
   endtask

   // Output monitor: every tick must match the oldest pending expectation.
   always @(negedge clk) begin
      check("a_vld_only_with_tick", {31'b0, if_a.frm_period_vld & ~if_a.frm_tick}, 0);
      check("b_vld_only_with_tick", {31'b0, if_b.frm_period_vld & ~if_b.frm_tick}, 0);
      if (prev_tick_a) check("a_tick_single", {31'b0, if_a.frm_tick}, 0);
      if (prev_tick_b) check("b_tick_single", {31'b0, if_b.frm_tick}, 0);
      if (if_a.frm_tick) sb_pop(0, 32'(if_a.frm_cnt), 32'(if_a.frm_period_vld), 32'(if_a.frm_period));
      if (if_b.frm_tick) sb_pop(1, 32'(if_b.frm_cnt), 32'(if_b.frm_period_vld), 32'(if_b.frm_period));
      prev_tick_a = if_a.frm_tick;
      prev_tick_b = if_b.frm_tick;
   end

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_cnt[d] = 0;
         m_ref[d] = 0;
         m_last[d] = 0;
         m_per[d] = 0;
      end
   endtask

   task automatic drive_active(input int d);
      exp_t e;
      int   gap;
      int   pmax;
      pmax     = (d == 0) ? A_PMAX : B_PMAX;
      m_cnt[d] = (m_cnt[d] == ((d == 0) ? A_CMAX : B_CMAX)) ? 0 : m_cnt[d] + 1;
      e.vld    = m_ref[d];
      if (m_ref[d] != 0) begin
         gap      = cyc - m_last[d];
         m_per[d] = (gap > pmax) ? pmax : gap;
      end
      m_ref[d]  = 1;
      m_last[d] = cyc;
      e.cnt     = m_cnt[d];
      e.per     = m_per[d];
      if (d == 0) begin
         if_a.vsync = 1'b1;
         q_a.push_back(e);
      end else begin
         if_b.vsync = 1'b0;
         q_b.push_back(e);
      end
   endtask

   task automatic drive_idle(input int d);
      if (d == 0) if_a.vsync = 1'b0;
      else        if_b.vsync = 1'b1;
   endtask

   task automatic run_frames(input int d, input int n, input int period);
      repeat (n) begin
         drive_active(d);
         wait_cyc(period / 2);
         drive_idle(d);
         wait_cyc(period - period / 2);
      end
   endtask

   task automatic chk_all_zero(input string pfx);
      check({pfx, "_a_tick"},  {31'b0, if_a.frm_tick}, 0);
      check({pfx, "_a_cnt"},   32'(if_a.frm_cnt), 0);
      check({pfx, "_a_per"},   32'(if_a.frm_period), 0);
      check({pfx, "_a_vld"},   {31'b0, if_a.frm_period_vld}, 0);
      check({pfx, "_a_sat"},   {31'b0, if_a.per_sat}, 0);
      check({pfx, "_a_lost"},  {31'b0, if_a.vs_lost}, 0);
      check({pfx, "_b_tick"},  {31'b0, if_b.frm_tick}, 0);
      check({pfx, "_b_cnt"},   32'(if_b.frm_cnt), 0);
      check({pfx, "_b_per"},   32'(if_b.frm_period), 0);
      check({pfx, "_b_vld"},   {31'b0, if_b.frm_period_vld}, 0);
      check({pfx, "_b_sat"},   {31'b0, if_b.per_sat}, 0);
      check({pfx, "_b_lost"},  {31'b0, if_b.vs_lost}, 0);
   endtask

   initial begin
      rst_n        = 1'b0;
      if_a.vsync   = 1'b0;
      if_a.cnt_clr = 1'b0;
      if_b.vsync   = 1'b1;
      if_b.cnt_clr = 1'b0;
      model_reset();
      wait_cyc(3);
      chk_all_zero("reset");
      rst_n = 1'b1;
      wait_cyc(5);

      // Instance A: first edge latency, then 100-cycle frames through the wrap
      drive_active(0);
      wait_cyc(2);
      check("a_latency_early", {31'b0, if_a.frm_tick}, 0);
      wait_cyc(1);
      check("a_latency_tick", {31'b0, if_a.frm_tick}, 1);
      wait_cyc(43);
      drive_idle(0);
      wait_cyc(50);
      run_frames(0, 6, 100);

      // Loss detection after a 300-cycle silence, recovery on a 500-cycle gap
      drive_active(0);
      wait_cyc(10);
      drive_idle(0);
      wait_cyc(292);
      check("a_lost_before_timeout", {31'b0, if_a.vs_lost}, 0);
      wait_cyc(1);
      check("a_lost_at_timeout", {31'b0, if_a.vs_lost}, 1);
      wait_cyc(197);
      drive_active(0);
      wait_cyc(3);
      check("a_lost_cleared", {31'b0, if_a.vs_lost}, 0);
      wait_cyc(10);
      drive_idle(0);
      wait_cyc(100);

      // Clear coincident with a detected edge discards the edge
      if_a.vsync = 1'b1;
      wait_cyc(2);
      if_a.cnt_clr = 1'b1;
      wait_cyc(1);
      check("a_clr_no_tick", {31'b0, if_a.frm_tick}, 0);
      check("a_clr_cnt", 32'(if_a.frm_cnt), 0);
      if_a.cnt_clr = 1'b0;
      m_cnt[0] = 0;
      m_ref[0] = 0;
      wait_cyc(10);
      drive_idle(0);
      wait_cyc(90);
      run_frames(0, 2, 100);

      // Reset in mid-frame
      drive_active(0);
      wait_cyc(20);
      drive_idle(0);
      wait_cyc(30);
      rst_n = 1'b0;
      wait_cyc(1);
      chk_all_zero("midrst");
      wait_cyc(1);
      rst_n = 1'b1;
      model_reset();
      wait_cyc(5);

      // Instance B: falling-edge frames, 50% duty, 200-cycle period
      run_frames(1, 4, 200);
      drive_active(1);
      wait_cyc(10);
      drive_idle(1);
      wait_cyc(390);
      check("b_lost_in_gap", {31'b0, if_b.vs_lost}, 1);
      drive_active(1);
      wait_cyc(3);
      check("b_sat_set", {31'b0, if_b.per_sat}, 1);
      check("b_lost_cleared", {31'b0, if_b.vs_lost}, 0);
      wait_cyc(10);
      drive_idle(1);
      wait_cyc(100);
      check("b_sat_sticky", {31'b0, if_b.per_sat}, 1);
      wait_cyc(87);
      drive_active(1);
      wait_cyc(3);
      check("b_sat_sticky_after_edge", {31'b0, if_b.per_sat}, 1);
      wait_cyc(10);
      drive_idle(1);
      wait_cyc(10);
      if_b.cnt_clr = 1'b1;
      wait_cyc(1);
      if_b.cnt_clr = 1'b0;
      check("b_clr_sat", {31'b0, if_b.per_sat}, 0);
      check("b_clr_cnt", 32'(if_b.frm_cnt), 0);
      check("b_clr_keeps_period", 32'(if_b.frm_period), 200);
      m_cnt[1] = 0;
      m_ref[1] = 0;
      wait_cyc(20);
      run_frames(1, 1, 200);

      wait_cyc(5);
      check("a_sb_drained", 32'(q_a.size()), 0);
      check("b_sb_drained", 32'(q_b.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
